// File: rtl/command_issuer.sv
// command_issuer: issues one framed command (CSN, command word, payload) and checks/forwards its response
// Ports:
//   clk, resetN                    clock, asynchronous active-low reset
//   cmd_start, cmd_word, pl_len    command request, sampled in IDLE
//   pl_data, pl_valid, pl_ready    payload source stream
//   tx_*                           AXI4-stream toward the channel FPGA
//   rx_*                           AXI4-stream back from the channel FPGA
//   rsp_data, rsp_valid, rsp_ready response payload stream to the user
//   busy, done, status, rsp_count, csn  progress and result reporting
module command_issuer #(
    parameter int TIMEOUT = 125000
) (
    input  logic        clk,
    input  logic        resetN,
    input  logic        cmd_start,
    input  logic [31:0] cmd_word,
    input  logic [7:0]  pl_len,
    input  logic [31:0] pl_data,
    input  logic        pl_valid,
    output logic        pl_ready,
    output logic [31:0] tx_data,
    output logic [3:0]  tx_tkeep,
    output logic        tx_tvalid,
    output logic        tx_tlast,
    input  logic        tx_tready,
    input  logic [31:0] rx_data,
    input  logic [3:0]  rx_tkeep,
    input  logic        rx_tvalid,
    input  logic        rx_tlast,
    output logic        rx_tready,
    output logic [31:0] rsp_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        busy,
    output logic        done,
    output logic [3:0]  status,
    output logic [7:0]  rsp_count,
    output logic [31:0] csn
);
    typedef enum logic [3:0] {
        IDLE, SEND_CSN, SEND_CMD, SEND_PL, WAIT_CSN, WAIT_CMD, RECV, DRAIN, DONE
    } state_t;

    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    state_t      state, state_d;
    logic [31:0] cmd_q;
    logic [7:0]  len_q;
    logic [7:0]  pl_cnt;
    logic [31:0] tmo_cnt;
    logic        tx_hs, rx_hs, wait_st, tmo_hit;
    logic        rx_tkeep_unused;

    assign rx_tkeep_unused = ^rx_tkeep;
    assign tx_tkeep = 4'b1111;
    assign busy     = state != IDLE;
    assign done     = state == DONE;
    assign tx_hs    = tx_tvalid && tx_tready;
    assign rx_hs    = rx_tvalid && rx_tready;
    assign wait_st  = state inside {WAIT_CSN, WAIT_CMD, RECV, DRAIN};
    // Timeout fires on the cycle the counter would reach TIMEOUT with no RX word arriving
    assign tmo_hit  = wait_st && !rx_hs && tmo_cnt == TMO_LAST;

    always_comb begin
        tx_data   = '0;
        tx_tvalid = 1'b0;
        tx_tlast  = 1'b0;
        pl_ready  = 1'b0;
        rx_tready = 1'b0;
        rsp_data  = '0;
        rsp_valid = 1'b0;
        case (state)
            SEND_CSN: begin
                tx_data   = csn;
                tx_tvalid = 1'b1;
            end
            SEND_CMD: begin
                tx_data   = cmd_q;
                tx_tvalid = 1'b1;
                tx_tlast  = len_q == 8'd0;
            end
            SEND_PL: begin
                tx_data   = pl_data;
                tx_tvalid = pl_valid;
                pl_ready  = tx_tready;
                tx_tlast  = pl_cnt == len_q - 8'd1;
            end
            WAIT_CSN, WAIT_CMD, DRAIN: rx_tready = 1'b1;
            RECV: begin
                rsp_data  = rx_data;
                rsp_valid = rx_tvalid;
                rx_tready = rsp_ready;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:     state_d = cmd_start ? SEND_CSN : IDLE;
            SEND_CSN: state_d = tx_hs ? SEND_CMD : SEND_CSN;
            SEND_CMD: state_d = !tx_hs ? SEND_CMD : (len_q == 8'd0 ? WAIT_CSN : SEND_PL);
            SEND_PL:  state_d = (tx_hs && tx_tlast) ? WAIT_CSN : SEND_PL;
            WAIT_CSN: state_d = !rx_hs ? WAIT_CSN : rx_tlast ? DONE : (rx_data != csn) ? DRAIN : WAIT_CMD;
            // A mismatching final word has nothing left to drain, so tlast wins
            WAIT_CMD: state_d = !rx_hs ? WAIT_CMD : rx_tlast ? DONE : (rx_data != cmd_q) ? DRAIN : RECV;
            RECV:     state_d = (rx_hs && rx_tlast) ? DONE : RECV;
            DRAIN:    state_d = (rx_hs && rx_tlast) ? DONE : DRAIN;
            DONE:     state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (tmo_hit) state_d = DONE;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state     <= IDLE;
            csn       <= '0;
            cmd_q     <= '0;
            len_q     <= '0;
            pl_cnt    <= '0;
            status    <= '0;
            rsp_count <= '0;
            tmo_cnt   <= '0;
        end else begin
            state <= state_d;
            if (state == IDLE && cmd_start) begin
                cmd_q     <= cmd_word;
                len_q     <= pl_len;
                csn       <= csn + 32'd1;
                status    <= '0;
                rsp_count <= '0;
                pl_cnt    <= '0;
            end
            if (state == SEND_PL && tx_hs) pl_cnt <= pl_cnt + 8'd1;
            if ((state_d == WAIT_CSN && state != WAIT_CSN) || rx_hs) tmo_cnt <= '0;
            else if (wait_st) tmo_cnt <= tmo_cnt + 32'd1;
            if (state == WAIT_CSN && rx_hs && rx_data != csn) status[0] <= 1'b1;
            if (state == WAIT_CSN && rx_hs && rx_tlast) status[2] <= 1'b1;
            if (state == WAIT_CMD && rx_hs && rx_data != cmd_q) status[1] <= 1'b1;
            if (tmo_hit) status[3] <= 1'b1;
            if (state == RECV && rx_hs && rsp_count != 8'hFF) rsp_count <= rsp_count + 8'd1;
        end
    end
endmodule

// File: tb/tb_command_issuer.sv
// tb_command_issuer: directed checks of command_issuer framing, response handling, timeout and reset
module tb_command_issuer;
    logic        clk = 1'b0;
    logic        resetN = 1'b0;
    logic        cmd_start = 1'b0;
    logic [31:0] cmd_word = '0;
    logic [7:0]  pl_len = '0;
    logic [31:0] pl_data = '0;
    logic        pl_valid = 1'b0;
    logic        pl_ready;
    logic [31:0] tx_data;
    logic [3:0]  tx_tkeep;
    logic        tx_tvalid, tx_tlast;
    logic        tx_tready = 1'b0;
    logic [31:0] rx_data = '0;
    logic [3:0]  rx_tkeep = 4'hF;
    logic        rx_tvalid = 1'b0;
    logic        rx_tlast = 1'b0;
    logic        rx_tready;
    logic [31:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready = 1'b1;
    logic        busy, done;
    logic [3:0]  status;
    logic [7:0]  rsp_count;
    logic [31:0] csn;

    command_issuer #(.TIMEOUT(100)) dut (
        .clk(clk), .resetN(resetN), .cmd_start(cmd_start), .cmd_word(cmd_word), .pl_len(pl_len),
        .pl_data(pl_data), .pl_valid(pl_valid), .pl_ready(pl_ready),
        .tx_data(tx_data), .tx_tkeep(tx_tkeep), .tx_tvalid(tx_tvalid), .tx_tlast(tx_tlast), .tx_tready(tx_tready),
        .rx_data(rx_data), .rx_tkeep(rx_tkeep), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast), .rx_tready(rx_tready),
        .rsp_data(rsp_data), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .busy(busy), .done(done), .status(status), .rsp_count(rsp_count), .csn(csn)
    );

    always #4 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int done_cnt = 0;
    bit rv_seen = 1'b0;

    logic [31:0] pl[8];
    int          npl;
    logic [31:0] txw[16];
    bit          txl[16];
    int          ntx;
    logic [31:0] rxw[8];
    logic [31:0] rspw[16];
    int          nrsp;
    bit          rx_all;

    always @(negedge clk) begin
        #2;
        if (done) done_cnt++;
        if (rsp_valid) rv_seen = 1'b1;
    end

    task automatic issue(input logic [31:0] cw, input logic [7:0] len);
        @(negedge clk);
        cmd_word  = cw;
        pl_len    = len;
        cmd_start = 1'b1;
        @(negedge clk);
        cmd_start = 1'b0;
    endtask

    task automatic run_tx(input bit toggle);
        int  pi = 0;
        bit  ok = 1'b0;
        ntx = 0;
        for (int c = 0; c < 200; c++) begin
            tx_tready = toggle ? (c % 2 == 0) : 1'b1;
            pl_valid  = pi < npl;
            pl_data   = (pi < npl) ? pl[pi] : '0;
            #1;
            if (tx_tvalid && tx_tready && ntx < 16) begin
                txw[ntx] = tx_data;
                txl[ntx] = tx_tlast;
                ntx++;
                if (pl_ready && pl_valid) pi++;
                if (tx_tlast) ok = 1'b1;
            end
            @(negedge clk);
            if (ok) break;
        end
        tx_tready = 1'b0;
        pl_valid  = 1'b0;
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL tx_frame: no tlast handshake within 200 cycles, got %0d words, required tlast", ntx);
        end
    endtask

    task automatic run_rx(input int n);
        int i = 0;
        bit hs;
        nrsp   = 0;
        rx_all = 1'b0;
        for (int c = 0; c < 200; c++) begin
            rx_tvalid = 1'b1;
            rx_data   = rxw[i];
            rx_tlast  = i == n - 1;
            #1;
            if (rsp_valid && rsp_ready && nrsp < 16) begin
                rspw[nrsp] = rsp_data;
                nrsp++;
            end
            hs = rx_tvalid && rx_tready;
            @(negedge clk);
            if (hs) i++;
            if (i == n) begin
                rx_all = 1'b1;
                break;
            end
        end
        rx_tvalid = 1'b0;
        rx_tlast  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({busy, done, tx_tvalid, tx_tlast, rx_tready, pl_ready, rsp_valid} !== 7'b0) begin
            miscompares++;
            $display("FAIL reset_ctl: got %b required 0000000", {busy, done, tx_tvalid, tx_tlast, rx_tready, pl_ready, rsp_valid});
        end
        vectors++;
        if (csn !== 32'h0 || status !== 4'h0 || rsp_count !== 8'h0 || tx_data !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_regs: csn=%h status=%h rsp_count=%h tx_data=%h required all 0", csn, status, rsp_count, tx_data);
        end
        vectors++;
        if (tx_tkeep !== 4'hF) begin
            miscompares++;
            $display("FAIL tkeep: got %h required f", tx_tkeep);
        end
        resetN = 1'b1;
    endtask

    task automatic test_loopback();
        logic [31:0] exp_tx[5];
        exp_tx = '{32'd1, 32'd1, 32'hA0A0_0001, 32'hB0B0_0002, 32'hC0C0_0003};
        pl[0] = 32'hA0A0_0001; pl[1] = 32'hB0B0_0002; pl[2] = 32'hC0C0_0003; npl = 3;
        issue(32'h0000_0001, 8'd3);
        run_tx(1'b0);
        vectors++;
        if (ntx !== 5) begin
            miscompares++;
            $display("FAIL loop_tx_count: got %0d required 5", ntx);
        end
        for (int i = 0; i < 5; i++) begin
            vectors++;
            if (txw[i] !== exp_tx[i] || txl[i] !== (i == 4)) begin
                miscompares++;
                $display("FAIL loop_tx_word%0d: got %h last=%b required %h last=%b", i, txw[i], txl[i], exp_tx[i], i == 4);
            end
        end
        rxw[0] = 32'd1; rxw[1] = 32'd1; rxw[2] = pl[0]; rxw[3] = pl[1]; rxw[4] = pl[2];
        done_cnt = 0;
        run_rx(5);
        repeat (3) @(negedge clk);
        vectors++;
        if (nrsp !== 3 || rspw[0] !== pl[0] || rspw[1] !== pl[1] || rspw[2] !== pl[2]) begin
            miscompares++;
            $display("FAIL loop_rsp: got n=%0d %h %h %h required n=3 %h %h %h", nrsp, rspw[0], rspw[1], rspw[2], pl[0], pl[1], pl[2]);
        end
        vectors++;
        if (rsp_count !== 8'd3 || status !== 4'h0 || done_cnt !== 1 || busy !== 1'b0 || csn !== 32'd1) begin
            miscompares++;
            $display("FAIL loop_result: rsp_count=%0d status=%h done=%0d busy=%b csn=%h required 3 0 1 0 1", rsp_count, status, done_cnt, busy, csn);
        end
    endtask

    task automatic test_zero_len();
        npl = 0;
        issue(32'h0000_0005, 8'd0);
        run_tx(1'b1);
        vectors++;
        if (ntx !== 2 || txw[0] !== 32'd2 || txw[1] !== 32'd5 || txl[0] !== 1'b0 || txl[1] !== 1'b1) begin
            miscompares++;
            $display("FAIL zero_tx: got n=%0d %h/%b %h/%b required n=2 2/0 5/1", ntx, txw[0], txl[0], txw[1], txl[1]);
        end
        rxw[0] = 32'd2; rxw[1] = 32'd5;
        done_cnt = 0;
        run_rx(2);
        repeat (3) @(negedge clk);
        vectors++;
        if (done_cnt !== 1 || rsp_count !== 8'd0 || status !== 4'h0 || nrsp !== 0) begin
            miscompares++;
            $display("FAIL zero_result: done=%0d rsp_count=%0d status=%h nrsp=%0d required 1 0 0 0", done_cnt, rsp_count, status, nrsp);
        end
    endtask

    task automatic test_csn_err();
        npl = 0;
        issue(32'h0000_0007, 8'd0);
        run_tx(1'b0);
        rxw[0] = 32'h0000_DEAD; rxw[1] = 32'd11; rxw[2] = 32'd12; rxw[3] = 32'd13; rxw[4] = 32'd14;
        done_cnt = 0;
        rv_seen  = 1'b0;
        run_rx(5);
        vectors++;
        if (rx_all !== 1'b1 || done_cnt !== 0) begin
            miscompares++;
            $display("FAIL csn_drain: consumed_all=%b done_before_tlast=%0d required 1 0", rx_all, done_cnt);
        end
        repeat (3) @(negedge clk);
        vectors++;
        if (status !== 4'b0001 || done_cnt !== 1 || rv_seen !== 1'b0) begin
            miscompares++;
            $display("FAIL csn_result: status=%b done=%0d rsp_valid_seen=%b required 0001 1 0", status, done_cnt, rv_seen);
        end
    endtask

    task automatic test_timeout();
        int k = 0;
        npl = 0;
        issue(32'h0000_0009, 8'd0);
        run_tx(1'b0);
        for (int c = 1; c <= 150; c++) begin
            @(negedge clk);
            #1;
            if (done) begin
                k = c;
                break;
            end
        end
        vectors++;
        if (k !== 100) begin
            miscompares++;
            $display("FAIL timeout_cycles: done after %0d cycles required 100", k);
        end
        vectors++;
        if (status !== 4'b1000 || rsp_count !== 8'd0) begin
            miscompares++;
            $display("FAIL timeout_status: status=%b rsp_count=%0d required 1000 0", status, rsp_count);
        end
    endtask

    task automatic test_csn_wrap();
        @(negedge clk);
        force dut.csn = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.csn;
        npl = 0;
        issue(32'h0000_0003, 8'd0);
        run_tx(1'b0);
        vectors++;
        if (ntx !== 2 || txw[0] !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_tx_csn: got n=%0d csn_word=%h required n=2 00000000", ntx, txw[0]);
        end
        rxw[0] = 32'h0; rxw[1] = 32'h3;
        done_cnt = 0;
        run_rx(2);
        repeat (3) @(negedge clk);
        vectors++;
        if (status !== 4'h0 || csn !== 32'h0 || done_cnt !== 1) begin
            miscompares++;
            $display("FAIL wrap_result: status=%h csn=%h done=%0d required 0 0 1", status, csn, done_cnt);
        end
    endtask

    task automatic test_async_reset();
        int pi = 0;
        pl[0] = 32'h1111_0000; pl[1] = 32'h2222_0000; pl[2] = 32'h3333_0000;
        pl[3] = 32'h4444_0000; pl[4] = 32'h5555_0000;
        issue(32'h0000_0004, 8'd5);
        tx_tready = 1'b1;
        pl_valid  = 1'b1;
        repeat (3) begin
            pl_data = pl[pi];
            #1;
            if (pl_ready) pi++;
            @(negedge clk);
        end
        pl_data = pl[pi];
        #1;
        vectors++;
        if (busy !== 1'b1 || tx_tvalid !== 1'b1 || tx_data !== pl[1]) begin
            miscompares++;
            $display("FAIL pre_reset: busy=%b tvalid=%b data=%h required 1 1 %h", busy, tx_tvalid, tx_data, pl[1]);
        end
        #1 resetN = 1'b0;
        #1;
        vectors++;
        if (busy !== 1'b0 || tx_tvalid !== 1'b0 || pl_ready !== 1'b0 || tx_data !== 32'h0) begin
            miscompares++;
            $display("FAIL async_reset: busy=%b tvalid=%b pl_ready=%b data=%h required 0 0 0 0", busy, tx_tvalid, pl_ready, tx_data);
        end
        tx_tready = 1'b0;
        pl_valid  = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        npl = 0;
        issue(32'h0000_0006, 8'd0);
        run_tx(1'b0);
        vectors++;
        if (txw[0] !== 32'd1 || csn !== 32'd1) begin
            miscompares++;
            $display("FAIL post_reset_csn: tx csn=%h reg csn=%h required 1 1", txw[0], csn);
        end
    endtask

    initial begin
        test_reset();
        test_loopback();
        test_zero_len();
        test_csn_err();
        test_timeout();
        test_csn_wrap();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/command_issuer.md
COMMAND_ISSUER -- requirements
Module: command_issuer

Interface
REQ-001 Parameter TIMEOUT, default 125000, response timeout in clk cycles with no RX handshake (1 ms at 125 MHz).
REQ-002 clk  in  1  125 MHz interconnect-side clock.
REQ-003 resetN  in  1  asynchronous, active-low reset.
REQ-004 cmd_start  in  1  request to issue one command; sampled only in IDLE.
REQ-005 cmd_word  in  32  command word; bits [4:0] hold the command code.
REQ-006 pl_len  in  8  payload word count, 0-255; sampled with cmd_start.
REQ-007 pl_data / pl_valid / pl_ready  in 32 / in 1 / out 1  payload source stream.
REQ-008 tx_data / tx_tkeep[0:3] / tx_tvalid / tx_tlast / tx_tready  out 32 / out 4 / out / out / in  AXI4-stream to the TX FIFO toward the channel FPGA.
REQ-009 rx_data / rx_tkeep[0:3] / rx_tvalid / rx_tlast / rx_tready  in 32 / in 4 / in / in / out  AXI4-stream from the RX FIFO.
REQ-010 rsp_data / rsp_valid / rsp_ready  out 32 / out 1 / in 1  response payload stream to the user.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 done  out  1  one-cycle pulse at command completion.
REQ-013 status  out  4  {timeout, len_err, cmd_err, csn_err}.
REQ-014 rsp_count  out  8  response payload words delivered, saturating at 255.
REQ-015 csn  out  32  serial number of the most recently issued command.

Function
REQ-016 States SHALL be IDLE, SEND_CSN, SEND_CMD, SEND_PL, WAIT_CSN, WAIT_CMD, RECV, DRAIN, DONE.
REQ-017 On cmd_start in IDLE: latch cmd_word and pl_len, set csn to csn+1 (modulo 2^32, 0xFFFFFFFF wraps to 0), clear status and rsp_count, enter SEND_CSN; cmd_start outside IDLE is ignored.
REQ-018 A word transfers only when tvalid and tready are both high; every state advance on a stream is gated by that handshake.
REQ-019 tx_tkeep SHALL be driven to 4'b1111 at all times.
REQ-020 SEND_CSN: tx_data=csn, tx_tvalid=1, tx_tlast=0; on handshake go to SEND_CMD.
REQ-021 SEND_CMD: tx_data=latched cmd_word, tx_tvalid=1, tx_tlast=(pl_len==0); on handshake go to SEND_PL if pl_len>0, else WAIT_CSN.
REQ-022 SEND_PL: tx_data=pl_data, tx_tvalid=pl_valid, pl_ready=tx_tready, tx_tlast high on word pl_len; after the last word go to WAIT_CSN; pl_ready=0 in all other states.
REQ-023 WAIT_CSN: rx_tready=1; if rx_data≠csn set csn_err; if rx_tlast set len_err and go to DONE, else go to DRAIN on mismatch, WAIT_CMD on match.
REQ-024 WAIT_CMD: rx_tready=1; compare all 32 bits to the latched cmd_word, setting cmd_err and going to DRAIN on mismatch; if rx_tlast go to DONE (zero-length response is legal); else go to RECV.
REQ-025 RECV: rsp_data=rx_data, rsp_valid=rx_tvalid, rx_tready=rsp_ready; each handshake increments rsp_count; rx_tlast handshake goes to DONE.
REQ-026 DRAIN: rx_tready=1, rsp_valid=0; discard words until an rx_tlast handshake, then go to DONE.
REQ-027 Timeout counter: cleared on entering WAIT_CSN and on every RX handshake; increments in WAIT_CSN, WAIT_CMD, RECV, DRAIN; on reaching TIMEOUT set timeout and go to DONE with no drain.
REQ-028 DONE: done=1 for exactly one cycle, then go to IDLE; status, rsp_count and csn hold until the next accepted cmd_start.
REQ-029 rx_tready=0 in IDLE, SEND_*, DONE; tx_tvalid=0 outside SEND_*; rsp_valid=0 outside RECV.
REQ-030 rx_tkeep is ignored; any RX words arriving in IDLE are left in the FIFO (rx_tready low).

Reset
REQ-031 resetN low SHALL force IDLE immediately, asynchronously, from any state, including mid-frame.
REQ-032 Reset values: csn=0, status=0, rsp_count=0, timeout counter=0, busy=0, done=0, tx_tvalid=0, tx_tlast=0, rx_tready=0, pl_ready=0, rsp_valid=0, tx_data=0.
REQ-033 A frame truncated by reset is not completed or flagged; recovery is the system's responsibility.

Verification
REQ-034 Loopback: cmd_word=0x00000001, pl_len=3, payload A,B,C, echo frame {1,0x1,A,B,C}+tlast -> TX {1,0x1,A,B,C(tlast)}, rsp A,B,C, rsp_count=3, status=0, one done pulse.
REQ-035 pl_len=0 with tx_tready toggling every cycle -> TX {csn,cmd(tlast)} with 2 handshakes only; response {csn,cmd(tlast)} -> done, rsp_count=0.
REQ-036 Response CSN=0xDEAD, 4 more words, tlast -> csn_err=1, all 5 words consumed, rsp_valid never high, done after tlast.
REQ-037 No response, TIMEOUT=100 -> timeout=1 and done exactly 100 cycles after the last TX handshake.
REQ-038 Preload csn=0xFFFFFFFF via 0xFFFFFFFF issues; next command sends CSN 0x00000000 and matches a 0 echo.
REQ-039 resetN asserted during SEND_PL word 2 of 5 -> busy=0 and tx_tvalid=0 without waiting for a clk edge; the next command is issued with csn=1.
